fp_exp_postscale: RTL and testbench

//  Downstream stage of the floating-point multiplier in the expanded-hyperbolic-CORDIC exponential path.

---
 rtl/fp_exp_postscale.sv | 114 +++++++++++
 tb/tb_fp_exp_postscale.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_exp_postscale.sv
// Scales an FP32 product by 2^k for the CORDIC exp path, buffered in a small FIFO.
// Optional sticky ovf/unf flags are built when EXP_STICKY_FLAGS_EN is defined.
module fp_exp_postscale #(
  parameter int P     = 32,
  parameter int EW    = 8,
  parameter int MW    = 23,
  parameter int KW    = 9,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [P-1:0]  in_data,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [P-1:0]  out_data,
  output logic          out_ovf,
  output logic          out_unf
`ifdef EXP_STICKY_FLAGS_EN
  ,
  input  logic          flag_clr,
  output logic          sticky_ovf,
  output logic          sticky_unf
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int NW = EW + 2;
  localparam int W  = P + 2;
  localparam logic signed [NW-1:0] EMAX = NW'((1 << EW) - 1);

  logic                 sgn;
  logic [EW-1:0]        e;
  logic [MW-1:0]        man;
  logic signed [NW-1:0] k_ext;
  logic signed [NW-1:0] en;
  logic [P-1:0]         res;
  logic                 ovf;
  logic                 unf;

  assign sgn   = in_data[P-1];
  assign e     = in_data[P-2:MW];
  assign man   = in_data[MW-1:0];
  assign k_ext = NW'($signed(in_k));
  assign en    = $signed({2'b00, e}) + k_ext;

  // Checked in priority order: specials first, then range limits.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unf = 1'b0;
    if (e == '1) begin
      res = in_data;
    end else if (e == '0) begin
      res = {sgn, {(P-1){1'b0}}};
    end else if (en >= EMAX) begin
      res = {sgn, {EW{1'b1}}, {MW{1'b0}}};
      ovf = 1'b1;
    end else if (en[NW-1] || en == '0) begin
      res = {sgn, {(P-1){1'b0}}};
      unf = 1'b1;
    end else begin
      res = {sgn, en[EW-1:0], man};
    end
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          acc;
  logic          pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_data, out_ovf, out_unf} =
    out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= {res, ovf, unf};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (acc && !pop) count <= count + 1'b1;
      else if (pop && !acc) count <= count - 1'b1;
    end
  end

`ifdef EXP_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      sticky_ovf <= (acc & ovf) | (sticky_ovf & ~flag_clr);
      sticky_unf <= (acc & unf) | (sticky_unf & ~flag_clr);
    end
  end
`endif

endmodule

// File: tb/tb_fp_exp_postscale.sv
// Randomised and directed bench for fp_exp_postscale.
// Reference: integer exponent arithmetic plus a result queue.
module tb_fp_exp_postscale;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [8:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;
`ifdef EXP_STICKY_FLAGS_EN
  logic        flag_clr;
  logic        sticky_ovf;
  logic        sticky_unf;
  bit          m_sovf;
  bit          m_sunf;
`endif

  int ncmp = 0;
  int nerr = 0;
  logic [33:0] q[$];

  fp_exp_postscale #(.P(32), .EW(8), .MW(23), .KW(9), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_k(in_k),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf),
    .out_unf(out_unf)
`ifdef EXP_STICKY_FLAGS_EN
    ,
    .flag_clr(flag_clr),
    .sticky_ovf(sticky_ovf),
    .sticky_unf(sticky_unf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // {data, ovf, unf} from the exponent rules using plain integers.
  function automatic logic [33:0] ref_scale(logic [31:0] d, logic [8:0] k);
    int e;
    int en;
    logic s;
    s  = d[31];
    e  = int'(d[30:23]);
    en = e + int'($signed(k));
    if (e == 255) return {d, 2'b00};
    if (e == 0) return {s, 31'd0, 2'b00};
    if (en >= 255) return {s, 8'hFF, 23'd0, 2'b10};
    if (en <= 0) return {s, 31'd0, 2'b01};
    return {s, en[7:0], d[22:0], 2'b00};
  endfunction

  // Advance one clock; report any pop and keep the model in step.
  task automatic tick(output bit popped,
                      output logic [33:0] got,
                      output logic [33:0] want);
    logic [33:0] r;
    @(negedge clk);
    popped = 1'b0;
    got    = '0;
    want   = '0;
    if (!rst_n) begin
      q.delete();
`ifdef EXP_STICKY_FLAGS_EN
      m_sovf = 1'b0;
      m_sunf = 1'b0;
`endif
    end else begin
      r = ref_scale(in_data, in_k);
      if (out_valid && out_ready) begin
        popped = 1'b1;
        got    = {out_data, out_ovf, out_unf};
        want   = (q.size() != 0) ? q.pop_front() : 34'h0;
      end
`ifdef EXP_STICKY_FLAGS_EN
      m_sovf = (in_valid && in_ready && r[1]) || (m_sovf && !flag_clr);
      m_sunf = (in_valid && in_ready && r[0]) || (m_sunf && !flag_clr);
`endif
      if (in_valid && in_ready) q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit p;
    logic [33:0] g, w;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_k = '0;
`ifdef EXP_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
    tick(p, g, w);
    tick(p, g, w);
    rst_n = 1'b1;
    ncmp++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    ncmp++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    ncmp++;
    if ({out_data, out_ovf, out_unf} !== 34'h0) begin
      nerr++;
      $display("FAIL reset_out got=%h/%b/%b want=0", out_data, out_ovf, out_unf);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vd [7];
    logic [8:0]  vk [7];
    logic [33:0] ve [7];
    bit p;
    logic [33:0] g, w;
    vd[0] = 32'h3F800000; vk[0] = 9'd3;   ve[0] = {32'h41000000, 2'b00};
    vd[1] = 32'hC0000000; vk[1] = 9'h1FF; ve[1] = {32'hBF800000, 2'b00};
    vd[2] = 32'h7F000000; vk[2] = 9'd1;   ve[2] = {32'h7F800000, 2'b10};
    vd[3] = 32'h3F800000; vk[3] = 9'h181; ve[3] = {32'h00000000, 2'b01};
    vd[4] = 32'h3F800000; vk[4] = 9'd127; ve[4] = {32'h7F000000, 2'b00};
    vd[5] = 32'h7FC00000; vk[5] = 9'd5;   ve[5] = {32'h7FC00000, 2'b00};
    vd[6] = 32'h80000000; vk[6] = 9'h19C; ve[6] = {32'h80000000, 2'b00};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data = vd[i];
      in_k = vk[i];
      tick(p, g, w);
      in_valid = 1'b0;
      ncmp++;
      if (out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL dir%0d_valid got=%b want=1", i, out_valid);
      end
      ncmp++;
      if ({out_data, out_ovf, out_unf} !== ve[i]) begin
        nerr++;
        $display("FAIL dir%0d_head got=%h want=%h", i,
                 {out_data, out_ovf, out_unf}, ve[i]);
      end
      tick(p, g, w);
      ncmp++;
      if (out_valid !== 1'b0 || out_data !== 32'h0) begin
        nerr++;
        $display("FAIL dir%0d_drain got=%b/%h want=0/0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vd [3];
    bit p;
    logic [33:0] g, w;
    int npop;
    vd[0] = 32'h40400000;
    vd[1] = 32'hC1200000;
    vd[2] = 32'h3E800000;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_k = 9'd2;
    in_data = vd[0];
    tick(p, g, w);
    ncmp++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL bp_ready1 got=%b want=1", in_ready);
    end
    in_data = vd[1];
    tick(p, g, w);
    ncmp++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_full got=%b want=0", in_ready);
    end
    in_data = vd[2];
    tick(p, g, w);
    ncmp++;
    if (in_ready !== 1'b0 || q.size() != 2) begin
      nerr++;
      $display("FAIL bp_held got=%b/%0d want=0/2", in_ready, q.size());
    end
    ncmp++;
    if ({out_data, out_ovf, out_unf} !== ref_scale(vd[0], 9'd2)) begin
      nerr++;
      $display("FAIL bp_head_stable got=%h want=%h",
               {out_data, out_ovf, out_unf}, ref_scale(vd[0], 9'd2));
    end
    out_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) in_valid = 1'b0;
      tick(p, g, w);
      if (p) begin
        npop++;
        ncmp++;
        if (g !== w) begin
          nerr++;
          $display("FAIL bp_pop%0d got=%h want=%h", npop, g, w);
        end
      end
    end
    ncmp++;
    if (npop != 3 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_count got=%0d/%b want=3/0", npop, out_valid);
    end
  endtask

  task automatic test_random();
    bit p;
    logic [33:0] g, w;
    logic [7:0] e;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0: e = 8'h00;
        1: e = 8'hFF;
        2: e = 8'(250 + $urandom_range(0, 4));
        3: e = 8'(1 + $urandom_range(0, 4));
        default: e = 8'($urandom);
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) < 3);
      in_data = {1'($urandom), e, 23'($urandom)};
      in_k = 9'($urandom);
`ifdef EXP_STICKY_FLAGS_EN
      flag_clr = ($urandom_range(0, 9) == 0);
`endif
      tick(p, g, w);
      if (p) begin
        ncmp++;
        if (g !== w) begin
          nerr++;
          $display("FAIL rnd_pop cyc=%0d got=%h want=%h", i, g, w);
        end
      end
      ncmp++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)) begin
        nerr++;
        $display("FAIL rnd_hs cyc=%0d got=%b/%b want=%b/%b", i, out_valid,
                 in_ready, q.size() != 0, q.size() != DEPTH);
      end
      if (q.size() == 0) begin
        ncmp++;
        if ({out_data, out_ovf, out_unf} !== 34'h0) begin
          nerr++;
          $display("FAIL rnd_empty cyc=%0d got=%h want=0", i, out_data);
        end
      end
`ifdef EXP_STICKY_FLAGS_EN
      ncmp++;
      if (sticky_ovf !== m_sovf || sticky_unf !== m_sunf) begin
        nerr++;
        $display("FAIL rnd_sticky cyc=%0d got=%b%b want=%b%b", i,
                 sticky_ovf, sticky_unf, m_sovf, m_sunf);
      end
`endif
    end
    in_valid = 1'b0;
`ifdef EXP_STICKY_FLAGS_EN
    flag_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    bit p;
    logic [33:0] g, w;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h7F000000;
    in_k = 9'd5;
    tick(p, g, w);
    in_data = 32'h00800000 | 32'h3F800000;
    in_k = 9'h100;
    tick(p, g, w);
    in_valid = 1'b0;
    ncmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL rm_full got=%b/%b want=1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    tick(p, g, w);
    rst_n = 1'b1;
    ncmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
      nerr++;
      $display("FAIL rm_reset got=%b/%b/%h want=0/1/0", out_valid, in_ready, out_data);
    end
`ifdef EXP_STICKY_FLAGS_EN
    ncmp++;
    if (sticky_ovf !== 1'b0 || sticky_unf !== 1'b0) begin
      nerr++;
      $display("FAIL rm_sticky got=%b%b want=00", sticky_ovf, sticky_unf);
    end
`endif
    out_ready = 1'b1;
    tick(p, g, w);
    ncmp++;
    if (p || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rm_no_stale got=%b/%b want=0/0", p, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
